// File: rtl/aud_pkg.sv
// Shared constants, state encoding and parity helper for the AES-style subframe packer.
package aud_pkg;

  localparam logic [3:0] PRE_Z = 4'h1;
  localparam logic [3:0] PRE_X = 4'h2;
  localparam logic [3:0] PRE_Y = 4'h3;

  localparam int BLOCK_LEN_DEF = 192;

  localparam int SF_PRE_LSB = 0;
  localparam int SF_AUD_LSB = 4;
  localparam int SF_V_BIT   = 28;
  localparam int SF_U_BIT   = 29;
  localparam int SF_C_BIT   = 30;
  localparam int SF_P_BIT   = 31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } aud_state_e;

  function automatic logic aud_parity(input logic [31:0] word);
    return ^word[30:4];
  endfunction

endpackage

// File: rtl/axis_aud_packer.sv
// Packs stereo PCM pairs into left/right AES-style subframes and tracks the channel-status block.
// Optional macro AUD_PACKER_SILENCE_EN inserts V=1 silence pairs when the PCM input runs dry.
module axis_aud_packer
  import aud_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
  input  logic                s_axis_aud_aclk,
  input  logic                s_axis_aud_aresetn,
  input  logic                cfg_enable,
  input  logic [31:0]         cfg_cs_word,
  input  logic [2*DATA_W-1:0] s_axis_pcm_tdata,
  input  logic                s_axis_pcm_tvalid,
  output logic                s_axis_pcm_tready,
  output logic [31:0]         m_axis_aud_tdata,
  output logic [2:0]          m_axis_aud_tid,
  output logic                m_axis_aud_tvalid,
  input  logic                m_axis_aud_tready,
  output logic [7:0]          frame_idx
`ifdef AUD_PACKER_SILENCE_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);

  localparam logic [7:0] FRAME_LAST = 8'(BLOCK_LEN - 1);

  aud_state_e        state_q, state_d;
  logic [31:0]       tdata_q, tdata_d;
  logic [2:0]        tid_q, tid_d;
  logic [DATA_W-1:0] r_smp_q, r_smp_d;
  logic              v_q, v_d;
  logic              c_q, c_d;
  logic [7:0]        frame_idx_q, frame_idx_d;
  logic [7:0]        frame_inc, frame_nxt;
  logic              m_hs, pcm_hs, load_sil, load_pair;
  logic [DATA_W-1:0] l_smp, r_smp;

  function automatic logic [31:0] build_sub(input logic [3:0] pre, input logic [DATA_W-1:0] smp,
                                            input logic v, input logic c);
    logic [31:0] w;
    w = '0;
    w[SF_PRE_LSB +: 4]  = pre;
    w[SF_AUD_LSB +: 24] = 24'(smp) << (24 - DATA_W);
    w[SF_V_BIT]         = v;
    w[SF_U_BIT]         = 1'b0;
    w[SF_C_BIT]         = c;
    w[SF_P_BIT]         = aud_parity(w);
    return w;
  endfunction

  function automatic logic cs_bit(input logic [31:0] cs, input logic [7:0] f);
    return (f[7:5] == 3'd0) ? cs[f[4:0]] : 1'b0;
  endfunction

  assign m_hs              = m_axis_aud_tvalid && m_axis_aud_tready;
  assign s_axis_pcm_tready = cfg_enable &&
                             (state_q == S_IDLE || (state_q == S_RIGHT && m_axis_aud_tready));
  assign pcm_hs            = s_axis_pcm_tready && s_axis_pcm_tvalid;
`ifdef AUD_PACKER_SILENCE_EN
  assign load_sil = cfg_enable && (state_q == S_IDLE) && !s_axis_pcm_tvalid;
`else
  assign load_sil = 1'b0;
`endif
  assign load_pair = pcm_hs || load_sil;

  always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
    if (!s_axis_aud_aresetn) state_q <= S_IDLE;
    else                     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (load_pair) state_d = S_LEFT;
      S_LEFT:  if (m_hs)      state_d = S_RIGHT;
      S_RIGHT: if (m_hs)      state_d = load_pair ? S_LEFT : S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // A pair loaded in the same cycle as the right handshake belongs to the next frame.
  always_comb begin
    frame_inc   = (frame_idx_q == FRAME_LAST) ? 8'd0 : frame_idx_q + 8'd1;
    frame_nxt   = (state_q == S_RIGHT && m_hs) ? frame_inc : frame_idx_q;
    frame_idx_d = (state_d == S_IDLE && !cfg_enable) ? 8'd0 : frame_nxt;
    l_smp       = load_sil ? '0 : s_axis_pcm_tdata[DATA_W-1:0];
    r_smp       = load_sil ? '0 : s_axis_pcm_tdata[2*DATA_W-1:DATA_W];
    tdata_d     = tdata_q;
    tid_d       = tid_q;
    r_smp_d     = r_smp_q;
    v_d         = v_q;
    c_d         = c_q;
    if (load_pair) begin
      c_d     = cs_bit(cfg_cs_word, frame_nxt);
      v_d     = load_sil;
      r_smp_d = r_smp;
      tid_d   = 3'd0;
      tdata_d = build_sub((frame_nxt == 8'd0) ? PRE_Z : PRE_X, l_smp, load_sil, c_d);
    end else if (state_q == S_LEFT && m_hs) begin
      tid_d   = 3'd1;
      tdata_d = build_sub(PRE_Y, r_smp_q, v_q, c_q);
    end
  end

  always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
    if (!s_axis_aud_aresetn) begin
      tdata_q     <= '0;
      tid_q       <= '0;
      r_smp_q     <= '0;
      v_q         <= 1'b0;
      c_q         <= 1'b0;
      frame_idx_q <= '0;
    end else begin
      tdata_q     <= tdata_d;
      tid_q       <= tid_d;
      r_smp_q     <= r_smp_d;
      v_q         <= v_d;
      c_q         <= c_d;
      frame_idx_q <= frame_idx_d;
    end
  end

`ifdef AUD_PACKER_SILENCE_EN
  logic [15:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (load_sil && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
    if (!s_axis_aud_aresetn) underrun_q <= '0;
    else                     underrun_q <= underrun_d;
  end

  assign underrun_cnt = underrun_q;
`endif

  assign m_axis_aud_tvalid = (state_q != S_IDLE);
  assign m_axis_aud_tdata  = tdata_q;
  assign m_axis_aud_tid    = tid_q;
  assign frame_idx         = frame_idx_q;

endmodule

// File: tb/tb_axis_aud_packer.sv
// Scoreboard bench for axis_aud_packer: driver queues expected subframes, monitor checks each output beat.
module tb_axis_aud_packer;

  localparam int DATA_W = 24;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  tid;
    logic [7:0]  frame;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_enable = 1'b0;
  logic [31:0]         cfg_cs_word = '0;
  logic [2*DATA_W-1:0] pcm_data = '0;
  logic                pcm_valid = 1'b0;
  logic                pcm_ready;
  logic [31:0]         m_data;
  logic [2:0]          m_tid;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [7:0]          frame_idx;
`ifdef AUD_PACKER_SILENCE_EN
  logic [15:0]         underrun_cnt;
`endif

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_frame = 0;
  int   last_hs = 0;
  bit   hs_seen = 1'b0;
  bit   burst = 1'b0;
  int   gap_err = 0;

  axis_aud_packer #(.DATA_W(DATA_W), .BLOCK_LEN(192)) dut (
    .s_axis_aud_aclk    (clk),
    .s_axis_aud_aresetn (rst_n),
    .cfg_enable         (cfg_enable),
    .cfg_cs_word        (cfg_cs_word),
    .s_axis_pcm_tdata   (pcm_data),
    .s_axis_pcm_tvalid  (pcm_valid),
    .s_axis_pcm_tready  (pcm_ready),
    .m_axis_aud_tdata   (m_data),
    .m_axis_aud_tid     (m_tid),
    .m_axis_aud_tvalid  (m_valid),
    .m_axis_aud_tready  (m_ready),
    .frame_idx          (frame_idx)
`ifdef AUD_PACKER_SILENCE_EN
    ,
    .underrun_cnt       (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference subframe with parity from an explicit bit count.
  function automatic logic [31:0] mk(input int frame, input bit right, input logic [23:0] s,
                                     input bit v, input bit c);
    logic [31:0] w;
    int ones;
    w = {4'b0, s, (right ? 4'h3 : ((frame == 0) ? 4'h1 : 4'h2))};
    w[28] = v;
    w[30] = c;
    ones = 0;
    for (int b = 4; b < 31; b++) ones += int'(w[b]);
    w[31] = ones[0];
    return w;
  endfunction

  function automatic bit cs_of(input logic [31:0] cs, input int frame);
    return (frame < 32) ? cs[frame] : 1'b0;
  endfunction

  task automatic push_pair(input logic [31:0] el, input logic [31:0] er);
    sb_q.push_back('{data: el, tid: 3'd0, frame: 8'(exp_frame)});
    sb_q.push_back('{data: er, tid: 3'd1, frame: 8'(exp_frame)});
    exp_frame = (exp_frame + 1) % 192;
  endtask

  task automatic send_exp(input logic [23:0] l, input logic [23:0] r,
                          input logic [31:0] el, input logic [31:0] er);
    int n;
    n = 0;
    push_pair(el, er);
    pcm_data  = {r, l};
    pcm_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (pcm_ready) break;
      n++;
      if (n > 200) begin
        chk("pcm_accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    pcm_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
    bit c;
    c = cs_of(cfg_cs_word, exp_frame);
    send_exp(l, r, mk(exp_frame, 1'b0, l, 1'b0, c), mk(exp_frame, 1'b1, r, 1'b0, c));
  endtask

  // Monitor: every accepted output beat is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", m_data, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("beat_tdata", m_data, e.data);
        chk("beat_tid", 32'(m_tid), 32'(e.tid));
        chk("beat_frame_idx", 32'(frame_idx), 32'(e.frame));
      end
    end
  end

  always @(negedge clk) begin
    if (pcm_valid && pcm_ready) begin
      if (burst && hs_seen && (cyc - last_hs) != 2) gap_err++;
      last_hs = cyc;
      hs_seen = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pcm_tready", 32'(pcm_ready), 32'd0);
    chk("rst_m_tvalid", 32'(m_valid), 32'd0);
    chk("rst_m_tdata", m_data, 32'd0);
    chk("rst_m_tid", 32'(m_tid), 32'd0);
    chk("rst_frame_idx", 32'(frame_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef AUD_PACKER_SILENCE_EN
    m_ready    = 1'b1;
    cfg_enable = 1'b1;
    for (int f = 0; f < 4; f++)
      push_pair(mk(f, 1'b0, 24'd0, 1'b1, 1'b0), mk(f, 1'b1, 24'd0, 1'b1, 1'b0));
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) break;
    end
    cfg_enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("sil_underrun_cnt", 32'(underrun_cnt), 32'd4);
    chk("sil_frame_idx", 32'(frame_idx), 32'd0);
    chk("sil_idle_tvalid", 32'(m_valid), 32'd0);
`else
    // Basic pairs, frames 0 and 1.
    cfg_enable = 1'b1;
    m_ready    = 1'b1;
    send_exp(24'h000001, 24'h000002, 32'h8000_0011, 32'h8000_0023);
    send_exp(24'h000003, 24'h000004, 32'h0000_0032, 32'h8000_0043);
    // Channel-status bit on frame 2 only.
    cfg_cs_word = 32'h0000_0004;
    send_exp(24'h000000, 24'h000000, 32'hC000_0002, 32'hC000_0003);
    send_exp(24'h000000, 24'h000000, 32'h0000_0002, 32'h0000_0003);
    cfg_cs_word = 32'h0;
    repeat (4) @(posedge clk);
    #1;

    // Enable dropped with a pair in flight.
    m_ready = 1'b0;
    send_exp(24'h000005, 24'h000006, 32'h0000_0052, 32'h0000_0063);
    cfg_enable = 1'b0;
    @(negedge clk);
    chk("dis_left_tvalid", 32'(m_valid), 32'd1);
    chk("dis_left_pcm_tready", 32'(pcm_ready), 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    chk("dis_right_tid", 32'(m_tid), 32'd1);
    chk("dis_right_pcm_tready", 32'(pcm_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("dis_idle_tvalid", 32'(m_valid), 32'd0);
    chk("dis_frame_idx", 32'(frame_idx), 32'd0);
    chk("dis_pcm_tready", 32'(pcm_ready), 32'd0);
    exp_frame  = 0;
    cfg_enable = 1'b1;
    @(posedge clk);
    #1;

    // Right beat stalled for 10 cycles.
    send_exp(24'h000007, 24'h000008, 32'h8000_0071, 32'h8000_0083);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_tvalid", 32'(m_valid), 32'd1);
      chk("stall_tdata", m_data, 32'h8000_0083);
      chk("stall_tid", 32'(m_tid), 32'd1);
      chk("stall_pcm_tready", 32'(pcm_ready), 32'd0);
    end
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Restart the block at frame 0, then 400 back-to-back pairs across two wraps.
    cfg_enable = 1'b0;
    @(posedge clk);
    #1;
    cfg_enable  = 1'b1;
    exp_frame   = 0;
    cfg_cs_word = 32'h8000_0005;
    hs_seen     = 1'b0;
    burst       = 1'b1;
    for (int i = 0; i < 400; i++)
      send_pair(24'(i * 5 + 1), 24'(i * 7 + 2) ^ 24'hA50000);
    burst = 1'b0;
    chk("burst_pcm_rate_gaps", 32'(gap_err), 32'd0);
    chk("burst_hs_seen", 32'(hs_seen), 32'd1);
`endif

    for (int n = 0; n < 50; n++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
